// File: rtl/command_issue_control.sv
// Command FIFO and credit-gated PSL command issue with sequential tags and buffer status.
// Optional CMD_OVERFLOW_CHECK_EN adds a sticky push-while-full flag and a simulation error.
package command_issue_control_pkg;
  typedef enum logic [12:0] {
    INVALID    = 13'h0000,
    READ_CL_NA = 13'h0A00,
    READ_CL_S  = 13'h0A50,
    WRITE_NA   = 13'h0D00,
    WRITE_MI   = 13'h0D60
  } psl_command_e;

  localparam logic [7:0] INVALID_ID = 8'hFF;

  typedef struct packed {
    logic         valid;
    psl_command_e command;
    logic [7:0]   cu_id;
    logic [63:0]  address;
    logic [11:0]  size;
  } CommandBufferLine;

  typedef struct packed {
    logic       valid;
    logic [7:0] tag;
    logic [7:0] response;
  } ResponseBufferLine;

  typedef struct packed {
    logic valid;
    logic empty;
    logic full;
    logic alfull;
  } BufferStatus;
endpackage

module command_issue_control
  import command_issue_control_pkg::*;
#(
  parameter int DEPTH         = 32,
  parameter int ALFULL_MARGIN = 4,
  parameter int CREDITS_MAX   = 64
) (
  input  logic              clock,
  input  logic              rstn,
  input  logic              enabled_in,
  input  logic [7:0]        croom_in,
  input  CommandBufferLine  command_in,
  input  ResponseBufferLine response_in,
  output CommandBufferLine  command_out,
  output logic [7:0]        command_tag_out,
  output BufferStatus       command_buffer_status,
  output logic              overflow_out
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] OCC_FULL   = (AW+1)'(DEPTH);
  localparam logic [AW:0] OCC_ALFULL = (AW+1)'(DEPTH - ALFULL_MARGIN);
  localparam logic [7:0]  CRED_MAX   = 8'(CREDITS_MAX);
  localparam CommandBufferLine IDLE_LINE = '{valid: 1'b0, command: INVALID, cu_id: INVALID_ID,
                                             address: '0, size: '0};

  typedef enum logic [1:0] {CMD_RESET, CMD_IDLE, CMD_INIT, CMD_RUN} state_e;

  state_e           state, state_nxt;
  logic             enabled_q;
  CommandBufferLine cmd_q;
  CommandBufferLine mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [AW:0]      occ;
  logic [7:0]       credits, credits_nxt, tag_ctr;
  logic [8:0]       cred_sum;
  logic             push, pop, full, empty;
  logic             unused_resp;

  assign unused_resp = ^{response_in.tag, response_in.response};

  assign empty = (occ == '0);
  assign full  = (occ == OCC_FULL);
  assign pop   = (state == CMD_RUN) && !empty && (credits != 8'd0);
  // A pop in the same cycle frees the slot, so a push into a full FIFO is still taken.
  assign push  = cmd_q.valid && (state != CMD_RESET) && (!full || pop);

  assign command_buffer_status = '{valid: !empty, empty: empty, full: full,
                                   alfull: (occ >= OCC_ALFULL)};

  always_comb begin
    state_nxt = state;
    case (state)
      CMD_RESET: state_nxt = CMD_IDLE;
      CMD_IDLE:  if (enabled_q) state_nxt = CMD_INIT;
      CMD_INIT:  state_nxt = CMD_RUN;
      CMD_RUN:   if (!enabled_q) state_nxt = CMD_IDLE;
      default:   state_nxt = CMD_RESET;
    endcase
  end

  always_comb begin
    cred_sum = {1'b0, credits} - 9'(pop) + 9'(response_in.valid);
    if (state == CMD_INIT)
      credits_nxt = (croom_in > CRED_MAX) ? CRED_MAX : croom_in;
    else if (cred_sum > {1'b0, CRED_MAX})
      credits_nxt = CRED_MAX;
    else
      credits_nxt = cred_sum[7:0];
  end

  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      state           <= CMD_RESET;
      enabled_q       <= 1'b0;
      cmd_q           <= '0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      occ             <= '0;
      credits         <= '0;
      tag_ctr         <= '0;
      command_out     <= IDLE_LINE;
      command_tag_out <= '0;
    end else begin
      state     <= state_nxt;
      enabled_q <= enabled_in;
      cmd_q     <= command_in;
      credits   <= credits_nxt;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) begin
        rd_ptr            <= rd_ptr + 1'b1;
        tag_ctr           <= tag_ctr + 8'd1;
        command_out       <= mem[rd_ptr];
        command_out.valid <= 1'b1;
        command_tag_out   <= tag_ctr;
      end else begin
        command_out.valid <= 1'b0;
      end
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: occ <= occ;
      endcase
    end
  end

  // Storage needs no reset: the pointers define which entries are live.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr] <= cmd_q;
  end

`ifdef CMD_OVERFLOW_CHECK_EN
  logic drop, overflow_q;
  assign drop = cmd_q.valid && (state != CMD_RESET) && full && !pop;
  always_ff @(posedge clock or negedge rstn) begin
    if (!rstn) begin
      overflow_q <= 1'b0;
    end else begin
      if (drop) overflow_q <= 1'b1;
`ifndef SYNTHESIS
      if (drop && !overflow_q) $error("command_issue_control: command pushed while FIFO full");
`endif
    end
  end
  assign overflow_out = overflow_q;
`else
  assign overflow_out = 1'b0;
`endif
endmodule
